// File: rtl/dep_pkg.sv
// Shared types and default sizing for the dependency-checking issue scheduler.
package dep_pkg;
    localparam int DEP_WIDTH     = 64;
    localparam int DEP_NUM_REQ   = 4;
    localparam int DEP_NUM_SLOTS = 3;

    typedef logic [$clog2(DEP_NUM_SLOTS)-1:0] slot_idx_t;
    typedef logic [$clog2(DEP_NUM_REQ)-1:0]   src_idx_t;

    // Keys narrower than DEP_WIDTH occupy the low bits of the key field.
    typedef struct packed {
        logic                 busy;
        logic [DEP_WIDTH-1:0] key;
    } slot_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past i_last and wraps.
module rr_arbiter #(
    parameter int n = 4
) (
    input  logic [n-1:0]         i_req,
    input  logic [$clog2(n)-1:0] i_last,
    output logic [n-1:0]         o_gnt,
    output logic [$clog2(n)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(n);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 1; k <= n; k++) begin
            w_pos = IW'((int'(i_last) + k) % n);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end
endmodule

// File: rtl/dep_issue_sched.sv
// Shares one pipeline among num_req requesters, holding back any request whose key is still in flight.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module dep_issue_sched
    import dep_pkg::*;
#(
    parameter int width     = DEP_WIDTH,
    parameter int num_req   = DEP_NUM_REQ,
    parameter int num_slots = DEP_NUM_SLOTS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_req-1:0]           req_valid,
    input  logic [num_req*width-1:0]     req_key,
    output logic [num_req-1:0]           req_ready,
    output logic                         iss_valid,
    output logic [width-1:0]             iss_key,
    output logic [$clog2(num_req)-1:0]   iss_src,
    output logic [$clog2(num_slots)-1:0] iss_slot,
    input  logic                         iss_ready,
    input  logic                         cmp_valid,
    input  logic [$clog2(num_slots)-1:0] cmp_slot,
    output logic [num_slots-1:0]         busy,
    output logic [15:0]                  stall_cnt,
    output logic                         err
);
    localparam int SRC_W  = $clog2(num_req);
    localparam int SLOT_W = $clog2(num_slots);

    slot_t              r_slots [num_slots];
    logic               r_iss_valid;
    logic [width-1:0]   r_iss_key;
    logic [SRC_W-1:0]   r_iss_src;
    logic [SLOT_W-1:0]  r_iss_slot;
    logic [SRC_W-1:0]   r_last_grant;
    logic [15:0]        r_stall_cnt;
    logic               r_err;

    logic [num_slots-1:0] w_busy;
    logic [num_req-1:0]   w_hit;
    logic [num_req-1:0]   w_eligible;
    logic                 w_free_any;
    logic [SLOT_W-1:0]    w_free_idx;
    logic [num_slots-1:0] w_cmp_hit;
    logic                 w_cmp_err;
    logic [num_req-1:0]   w_arb_gnt;
    logic [SRC_W-1:0]     w_arb_idx;
    logic                 w_arb_any;
    logic                 w_can_load;
    logic                 w_grant_ok;
    logic                 w_grant;
    logic [width-1:0]     w_grant_key;

    always_comb begin
        w_busy = '0;
        w_hit  = '0;
        for (int s = 0; s < num_slots; s++) begin
            w_busy[s] = r_slots[s].busy;
            for (int i = 0; i < num_req; i++) begin
                if (r_slots[s].busy && r_slots[s].key[width-1:0] == req_key[i*width +: width])
                    w_hit[i] = 1'b1;
            end
        end
    end

    assign w_eligible = req_valid & ~w_hit;

    // A slot freed this cycle is still busy here, so it is neither matched away nor reallocated until next cycle.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int s = num_slots - 1; s >= 0; s--) begin
            if (!r_slots[s].busy) begin
                w_free_any = 1'b1;
                w_free_idx = SLOT_W'(s);
            end
        end
    end

    always_comb begin
        w_cmp_hit = '0;
        for (int s = 0; s < num_slots; s++) begin
            if (cmp_valid && cmp_slot == SLOT_W'(s) && r_slots[s].busy)
                w_cmp_hit[s] = 1'b1;
        end
    end

    assign w_cmp_err = cmp_valid && (w_cmp_hit == '0);

    rr_arbiter #(.n(num_req)) u_arb (
        .i_req  (w_eligible),
        .i_last (r_last_grant),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_any  (w_arb_any)
    );

    assign w_can_load  = ~r_iss_valid | iss_ready;
    assign w_grant_ok  = w_can_load & w_free_any & ~rst;
    assign w_grant     = w_grant_ok & w_arb_any;
    assign w_grant_key = req_key[w_arb_idx*width +: width];
    assign req_ready   = w_grant_ok ? w_arb_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < num_slots; s++) r_slots[s] <= '0;
            r_iss_valid  <= 1'b0;
            r_iss_key    <= '0;
            r_iss_src    <= '0;
            r_iss_slot   <= '0;
            r_last_grant <= SRC_W'(num_req - 1);
            r_stall_cnt  <= '0;
            r_err        <= 1'b0;
        end else begin
            for (int s = 0; s < num_slots; s++) begin
                if (w_grant && w_free_idx == SLOT_W'(s)) begin
                    r_slots[s].busy <= 1'b1;
                    r_slots[s].key  <= DEP_WIDTH'(w_grant_key);
                end else if (w_cmp_hit[s]) begin
                    r_slots[s].busy <= 1'b0;
                end
            end
            if (w_grant) begin
                r_iss_valid  <= 1'b1;
                r_iss_key    <= w_grant_key;
                r_iss_src    <= w_arb_idx;
                r_iss_slot   <= w_free_idx;
                r_last_grant <= w_arb_idx;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end
            if (w_can_load && (|req_valid) && !w_grant && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_cmp_err)
                r_err <= 1'b1;
        end
    end

    assign iss_valid = r_iss_valid;
    assign iss_key   = r_iss_key;
    assign iss_src   = r_iss_src;
    assign iss_slot  = r_iss_slot;
    assign busy      = w_busy;
    assign stall_cnt = r_stall_cnt;
    assign err       = r_err;
endmodule

// File: tb/tb_dep_issue_sched.sv
// Bench for dep_issue_sched: directed phases plus random traffic against a rule-level reference model.
module tb_dep_issue_sched;
    import dep_pkg::*;

    localparam int W  = DEP_WIDTH;
    localparam int NR = DEP_NUM_REQ;
    localparam int NS = DEP_NUM_SLOTS;
    localparam int SW = $clog2(NS);
    localparam int RW = $clog2(NR);
    localparam int EW = W + RW + SW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_key;
    logic [NR-1:0]     req_ready;
    logic              iss_valid;
    logic [W-1:0]      iss_key;
    src_idx_t          iss_src;
    slot_idx_t         iss_slot;
    logic              iss_ready;
    logic              cmp_valid;
    slot_idx_t         cmp_slot;
    logic [NS-1:0]     busy;
    logic [15:0]       stall_cnt;
    logic              err;

    always #5 clk = ~clk;

    dep_issue_sched #(.width(W), .num_req(NR), .num_slots(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_key   (req_key),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_key   (iss_key),
        .iss_src   (iss_src),
        .iss_slot  (iss_slot),
        .iss_ready (iss_ready),
        .cmp_valid (cmp_valid),
        .cmp_slot  (cmp_slot),
        .busy      (busy),
        .stall_cnt (stall_cnt),
        .err       (err)
    );

    // Expected issue entries: {key, src, slot}
    logic [EW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [NS-1:0] m_busy;
    logic [W-1:0]  m_key [NS];
    int            m_last;
    logic          m_iv;
    int            m_stall;
    logic          m_err;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = '0;
        for (int s = 0; s < NS; s++) m_key[s] = '0;
        m_last  = NR - 1;
        m_iv    = 1'b0;
        m_stall = 0;
        m_err   = 1'b0;
    endtask

    function automatic logic key_in_flight(input logic [W-1:0] k);
        for (int s = 0; s < NS; s++)
            if (m_busy[s] && m_key[s] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NR*W-1:0] keys(input logic [W-1:0] k0, input logic [W-1:0] k1,
                                             input logic [W-1:0] k2, input logic [W-1:0] k3);
        return {k3, k2, k1, k0};
    endfunction

    // Reference model: evaluates each cycle's rules from its own state and the applied inputs
    always @(negedge clk) begin : model
        logic          can_load;
        logic          free_any;
        int            fslot;
        int            win;
        int            idx;
        logic [NR-1:0] exp_rdy;
        if (rst) begin
            check("ready_in_reset", W'(req_ready), '0);
            model_reset();
            exp_q.delete();
        end else begin
            check("busy", W'(busy), W'(m_busy));
            check("stall_cnt", W'(stall_cnt), W'(m_stall));
            check("err", W'(err), W'(m_err));
            check("iss_valid", W'(iss_valid), W'(m_iv));
            can_load = !m_iv || iss_ready;
            free_any = 1'b0;
            fslot    = 0;
            for (int s = NS - 1; s >= 0; s--)
                if (!m_busy[s]) begin free_any = 1'b1; fslot = s; end
            win = -1;
            if (can_load && free_any) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (m_last + k) % NR;
                    if (win < 0 && req_valid[idx] && !key_in_flight(req_key[idx*W +: W])) win = idx;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            check("req_ready", W'(req_ready), W'(exp_rdy));
            if (cmp_valid) begin
                if (int'(cmp_slot) < NS && m_busy[cmp_slot]) m_busy[cmp_slot] = 1'b0;
                else m_err = 1'b1;
            end
            if (win >= 0) begin
                exp_q.push_back({req_key[win*W +: W], RW'(win), SW'(fslot)});
                m_busy[fslot] = 1'b1;
                m_key[fslot]  = req_key[win*W +: W];
                m_last        = win;
                m_iv          = 1'b1;
            end else if (iss_ready) begin
                m_iv = 1'b0;
            end
            if (can_load && (|req_valid) && win < 0 && m_stall < 65535) m_stall++;
        end
    end

    // Monitor: compares the output register against the oldest expected issue
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (!rst && iss_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL iss_unexpected: actual src=%0d key=%0h required=no issue at %0t", iss_src, iss_key, $time);
            end else begin
                e = exp_q[0];
                check("iss_key", iss_key, e[EW-1 -: W]);
                check("iss_src", W'(iss_src), W'(e[SW +: RW]));
                check("iss_slot", W'(iss_slot), W'(e[SW-1:0]));
                if (iss_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [NR-1:0] v, input logic [NR*W-1:0] k, input logic ir,
                         input logic cv, input logic [SW-1:0] cs);
        req_valid = v;
        req_key   = k;
        iss_ready = ir;
        cmp_valid = cv;
        cmp_slot  = cs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NR*W-1:0] rr_keys;
        model_reset();
        rr_keys = keys(64'h10, 64'h20, 64'h30, 64'h40);

        // Reset with every requester asserting
        rst = 1'b1;
        drive(4'hF, rr_keys, 1'b1, 1'b0, '0);
        drive(4'hF, rr_keys, 1'b1, 1'b0, '0);
        rst = 1'b0;
        check("rst_iss_valid", W'(iss_valid), '0);
        check("rst_iss_key", iss_key, '0);
        check("rst_iss_src", W'(iss_src), '0);
        check("rst_iss_slot", W'(iss_slot), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_stall", W'(stall_cnt), '0);
        check("rst_err", W'(err), '0);

        // Round-robin, each issue completed one cycle after it appears
        drive(4'hF, rr_keys, 1'b1, 1'b0, 2'd0);
        drive(4'hF, rr_keys, 1'b1, 1'b1, 2'd0);
        drive(4'hF, rr_keys, 1'b1, 1'b1, 2'd1);
        drive(4'hF, rr_keys, 1'b1, 1'b1, 2'd0);
        drive(4'hF, rr_keys, 1'b1, 1'b1, 2'd1);
        drive(4'h0, rr_keys, 1'b1, 1'b1, 2'd0);

        // Dependency stall on key 0xAA
        drive(4'b0001, keys(64'hAA, 0, 0, 0), 1'b1, 1'b0, '0);
        repeat (3) drive(4'b0100, keys(0, 0, 64'hAA, 0), 1'b1, 1'b0, '0);
        drive(4'b0100, keys(0, 0, 64'hAA, 0), 1'b1, 1'b1, 2'd0);
        drive(4'b0100, keys(0, 0, 64'hAA, 0), 1'b1, 1'b0, '0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd0);

        // Slots full
        drive(4'b0001, keys(64'h51, 0, 0, 0), 1'b1, 1'b0, '0);
        drive(4'b0010, keys(0, 64'h52, 0, 0), 1'b1, 1'b0, '0);
        drive(4'b0100, keys(0, 0, 64'h53, 0), 1'b1, 1'b0, '0);
        check("slots_full_busy", W'(busy), W'(3'b111));
        repeat (3) drive(4'b1000, keys(0, 0, 0, 64'h54), 1'b1, 1'b0, '0);
        drive(4'b1000, keys(0, 0, 0, 64'h54), 1'b1, 1'b1, 2'd1);
        drive(4'b1000, keys(0, 0, 0, 64'h54), 1'b1, 1'b0, '0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd1);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd2);

        // Backpressure
        drive(4'b0001, keys(64'h61, 0, 0, 0), 1'b0, 1'b0, '0);
        repeat (5) drive(4'b0010, keys(0, 64'h62, 0, 0), 1'b0, 1'b0, '0);
        drive(4'b0010, keys(0, 64'h62, 0, 0), 1'b1, 1'b0, '0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd1);

        // Completions on a free slot and an out-of-range slot
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd2);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd3);
        check("err_sticky", W'(err), W'(1'b1));
        check("err_busy_kept", W'(busy), '0);

        // Completion and grant in the same cycle
        drive(4'b0001, keys(64'h71, 0, 0, 0), 1'b1, 1'b0, '0);
        drive(4'b0010, keys(0, 64'h72, 0, 0), 1'b1, 1'b1, 2'd0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd1);

        // Random traffic over a small key space to provoke conflicts
        for (int c = 0; c < 600; c++) begin
            logic [NR-1:0]   v;
            logic [NR*W-1:0] k;
            logic            cv;
            logic [SW-1:0]   cs;
            int              s;
            v = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) k[i*W +: W] = W'($urandom_range(0, 7));
            cv = 1'b0;
            cs = '0;
            if ($urandom_range(0, 9) < 5) begin
                s = $urandom_range(0, NS - 1);
                if (m_busy[s]) begin cv = 1'b1; cs = SW'(s); end
            end
            if ($urandom_range(0, 49) == 0) begin cv = 1'b1; cs = SW'($urandom_range(0, 3)); end
            drive(v, k, ($urandom_range(0, 3) != 0), cv, cs);
        end

        // Reset with a slot in flight, then return that slot
        drive(4'b0000, '0, 1'b1, 1'b0, '0);
        drive(4'b0000, '0, 1'b1, 1'b0, '0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd1);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd2);
        drive(4'b0001, keys(64'h81, 0, 0, 0), 1'b1, 1'b0, '0);
        rst = 1'b1;
        drive(4'hF, rr_keys, 1'b1, 1'b0, '0);
        drive(4'hF, rr_keys, 1'b1, 1'b0, '0);
        rst = 1'b0;
        check("reset_mid_busy", W'(busy), '0);
        check("reset_mid_err", W'(err), '0);
        drive(4'b0000, '0, 1'b1, 1'b1, 2'd0);
        check("stale_cmp_err", W'(err), W'(1'b1));

        repeat (4) drive(4'b0000, '0, 1'b1, 1'b0, '0);
        check("queue_drained", W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dep_issue_sched.md
# dep_issue_sched

Issue scheduler that shares one downstream execution pipeline among `num_req` requesters. It blocks any request whose key matches a key still in flight. In-flight keys are held in a `num_slots`-entry scoreboard. A slot is allocated at grant and freed by a completion return. The block sits in front of the pipeline, replaces per-requester dependency buffers with one arbitrated check, and issues at most one request per cycle through a registered output stage.

## Interface
Parameters:
- `width`, default 64: key/data width.
- `num_req`, default 4: number of requesters; must be at least 2.
- `num_slots`, default 3: in-flight scoreboard entries.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `req_valid`, in, `num_req`: request pending, one bit per requester.
- `req_key`, in, `num_req` x `width`: key per requester.
- `req_ready`, out, `num_req`: one-hot grant; request is accepted when `req_valid[i]` and `req_ready[i]` are both high.
- `iss_valid`, out, 1: output register holds an issued request.
- `iss_key`, out, `width`: issued key.
- `iss_src`, out, `$clog2(num_req)`: index of the granted requester.
- `iss_slot`, out, `$clog2(num_slots)`: scoreboard slot allocated to the issued request.
- `iss_ready`, in, 1: downstream takes the issued request.
- `cmp_valid`, in, 1: completion return.
- `cmp_slot`, in, `$clog2(num_slots)`: slot being freed.
- `busy`, out, `num_slots`: slot-occupied vector.
- `stall_cnt`, out, 16: saturating count of dependency stalls.
- `err`, out, 1: sticky; completion arrived for a free or out-of-range slot.

## Operation
- Scoreboard: each slot holds a busy bit and a key.
- `can_load` = `~iss_valid | iss_ready`.
- Eligible(i) = `req_valid[i]` and `req_key[i]` differs from the key of every busy slot.
- Grant condition: `can_load`, at least one requester eligible, and at least one slot free at the start of the cycle.
- Arbitration: round-robin over eligible requesters, starting at `last_grant+1` mod `num_req`. `last_grant` updates only on a grant.
- At most one grant per cycle. `req_ready` is combinational from current state and inputs, and is one-hot or zero.
- On grant:
  - Load `iss_key`, `iss_src` and `iss_slot` into the output register.
  - Allocate the lowest-index free slot: set busy, store the key.
  - Set `iss_valid`.
- If `can_load` and there is no grant, `iss_valid` clears when `iss_ready` is high, and holds otherwise.
- While `iss_valid` and not `iss_ready`, the output register is stable: key, src and slot do not change.
- Completion: when `cmp_valid` and `busy[cmp_slot]`, clear `busy[cmp_slot]` at the clock edge.
- If `cmp_valid` targets a slot that is not busy, or `cmp_slot >= num_slots`, ignore the completion and set `err`.
- Simultaneous completion and grant in one cycle:
  - The slot being freed still counts as busy for both the dependency match and allocation in that cycle. This is conservative; the slot is usable the next cycle.
  - A grant and a completion never touch the same slot in the same cycle.
- Same key from two requesters in one cycle: only one can be granted. The next cycle, the other matches the newly allocated slot and stalls until that slot completes.
- `stall_cnt` increments (saturating at 0xFFFF) in every cycle where `can_load` is high, some `req_valid` is high, and no grant occurs. This includes the slots-full case.

## Timing
- Reset values:
  - `iss_valid`=0, `iss_key`=0, `iss_src`=0, `iss_slot`=0.
  - `busy`=0, `stall_cnt`=0, `err`=0.
  - `last_grant`=`num_req-1`, so requester 0 has first priority.
- `req_ready` is 0 while `rst` is high.
- Latency: request accepted in cycle N; `iss_valid` is high in cycle N+1.
- Throughput: one issue per cycle while `iss_ready` is held high and slots are available.
- A completion in cycle N makes the freed slot, and its key, available for match and allocation in cycle N+1.
- Reset mid-operation: all in-flight state is discarded. Completions arriving after reset for previously allocated slots set `err`.

## Structure
- Package `dep_pkg`:
  - `slot_idx_t` and `src_idx_t` typedefs.
  - A `slot_t` struct holding `busy` and `key`.
  - Default constants for `num_req` and `num_slots`.
- Sub-module `rr_arbiter`, parameter `n`:
  - Inputs: request vector, `last_grant` pointer.
  - Outputs: one-hot grant and its index.
  - Purely combinational; the pointer register stays in `dep_issue_sched`.
- Scoreboard match, lowest-free-slot selection, output register and counters are implemented in `dep_issue_sched`.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `req_valid` high. Required: `req_ready`=0 during reset; all outputs at reset values. First grant after reset goes to requester 0.
- **Round-robin:** all 4 requesters valid with distinct keys 0x10, 0x20, 0x30, 0x40; `iss_ready`=1; a completion returns one cycle after each issue. Required: `iss_src` sequence 0,1,2,3,0; one issue per cycle.
- **Dependency stall:**
  - Issue key 0xAA into slot 0.
  - Requester 2 then presents 0xAA. Required: no grant and `stall_cnt` increments each cycle.
  - Return `cmp_slot`=0. Required: grant to requester 2 in the next cycle, `iss_slot`=0.
- **Slots full:** issue 3 distinct keys without completions; a fourth distinct key is presented. Required: stall with `busy`=3'b111. One completion on slot 1 leads to the next issue with `iss_slot`=1.
- **Backpressure:** `iss_ready`=0 for 5 cycles while `iss_valid`=1. Required: key, src and slot stable; no further grants. Release `iss_ready`. Required: the next grant occurs in that same cycle.
- **Errors and simultaneous events:**
  - `cmp_valid` on a free slot 2. Required: `err`=1 and stays high; `busy` is unchanged.
  - Completion on slot 0 in the same cycle as a grant. Required: the new request is allocated to slot 1, not slot 0.
